// File: rtl/rv32m_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rv32m_div_sequencer
// Brief    : Radix-2 restoring divider with its own sequencer for RV32M
//            DIV/DIVU/REM/REMU; stalls the PC and gates write-back.
// Revision : 1.0 - initial release
// ============================================================================
module rv32m_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             CPU_clk,
    input  logic             CPU_rst,
    input  logic             Start,
    input  logic [1:0]       DivOp,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             PCWrite,
    output logic             RegWriteEn
);

    localparam int         c_CNT_W  = $clog2(WIDTH) + 1;
    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_CALC = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;
    localparam logic [WIDTH-1:0]   c_INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [c_CNT_W-1:0] c_ITERS   = c_CNT_W'(WIDTH);

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dsr;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_op_rem;
    logic [WIDTH-1:0]   r_result;

    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic               w_div_zero;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_special_res;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_nx;
    logic [WIDTH-1:0]   w_quo_nx;
    logic [WIDTH-1:0]   w_final;

    // Operand conditioning; negating INT_MIN wraps to itself, which is the
    // correct magnitude when read as unsigned.
    assign w_signed   = ~DivOp[0];
    assign w_a_neg    = w_signed & Dividend[WIDTH-1];
    assign w_b_neg    = w_signed & Divisor[WIDTH-1];
    assign w_a_abs    = w_a_neg ? (~Dividend + 1'b1) : Dividend;
    assign w_b_abs    = w_b_neg ? (~Divisor + 1'b1)  : Divisor;
    assign w_div_zero = (Divisor == '0);
    assign w_ovf      = w_signed & (Dividend == c_INT_MIN) & (Divisor == '1);

    assign w_special_res = w_div_zero ? (DivOp[1] ? Dividend : '1)
                                      : (DivOp[1] ? '0 : Dividend);

    // One restoring step: shift {rem,quo} left, trial-subtract the divisor.
    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_dsr};
    assign w_ge     = ~w_diff[WIDTH];
    assign w_rem_nx = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_quo_nx = {r_quo[WIDTH-2:0], w_ge};
    assign w_final  = r_op_rem ? (r_neg_r ? (~w_rem_nx + 1'b1) : w_rem_nx)
                               : (r_neg_q ? (~w_quo_nx + 1'b1) : w_quo_nx);

    always_ff @(posedge CPU_clk) begin
        if (CPU_rst) begin
            r_state  <= c_S_IDLE;
            r_count  <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dsr    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_op_rem <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (Start) begin
                        r_op_rem <= DivOp[1];
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        if (w_div_zero || w_ovf) begin
                            r_result <= w_special_res;
                            r_state  <= c_S_DONE;
                        end else begin
                            r_rem   <= '0;
                            r_quo   <= w_a_abs;
                            r_dsr   <= w_b_abs;
                            r_count <= c_ITERS;
                            r_state <= c_S_CALC;
                        end
                    end
                end
                c_S_CALC: begin
                    r_rem   <= w_rem_nx;
                    r_quo   <= w_quo_nx;
                    r_count <= r_count - 1'b1;
                    if (r_count == c_CNT_W'(1)) begin
                        r_result <= w_final;
                        r_state  <= c_S_DONE;
                    end
                end
                c_S_DONE: begin
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    // Reset overrides every handshake output so the pipeline never stalls
    // or writes back while the core is being reset.
    assign Busy       = ~CPU_rst & (r_state == c_S_CALC);
    assign Done       = ~CPU_rst & (r_state == c_S_DONE);
    assign RegWriteEn = Done;
    assign PCWrite    = CPU_rst | ~(((r_state == c_S_IDLE) & Start) | (r_state == c_S_CALC));
    assign Result     = r_result;

endmodule
`default_nettype wire

// File: tb/tb_rv32m_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32m_div_sequencer
// Brief    : Directed and random checks of rv32m_div_sequencer against an
//            arithmetic reference of the RV32M divide rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32m_div_sequencer;

    localparam int c_WIDTH = 32;

    logic              CPU_clk = 1'b0;
    logic              CPU_rst = 1'b1;
    logic              Start   = 1'b0;
    logic [1:0]        DivOp   = 2'b00;
    logic [31:0]       Dividend = '0;
    logic [31:0]       Divisor  = '0;
    logic              Busy;
    logic              Done;
    logic [31:0]       Result;
    logic              PCWrite;
    logic              RegWriteEn;

    int r_total = 0;
    int r_fails = 0;

    rv32m_div_sequencer #(.WIDTH(c_WIDTH)) u_dut (
        .CPU_clk    (CPU_clk),
        .CPU_rst    (CPU_rst),
        .Start      (Start),
        .DivOp      (DivOp),
        .Dividend   (Dividend),
        .Divisor    (Divisor),
        .Busy       (Busy),
        .Done       (Done),
        .Result     (Result),
        .PCWrite    (PCWrite),
        .RegWriteEn (RegWriteEn)
    );

    always #5 CPU_clk = ~CPU_clk;

    task automatic tick();
        @(posedge CPU_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_total++;
        assert (obs === exp) else begin
            r_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // RISC-V divide semantics expressed with plain integer arithmetic.
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb;
        if (b == 32'd0)
            return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'd0 : 32'h8000_0000;
        if (op[0])
            return op[1] ? (a % b) : (a / b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    function automatic bit is_special(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Issues one divide. b2b: called while the previous op is in DONE with
    // Start still high. hold: leave Start high after DONE for a follow-on op.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit b2b, input bit hold);
        logic [31:0] exp_res;
        int          exp_lat;
        int          n;
        int          busy_n;
        int          pc_bad;
        exp_res = ref_div(op, a, b);
        exp_lat = is_special(op, a, b) ? 1 : c_WIDTH + 1;
        DivOp    = op;
        Dividend = a;
        Divisor  = b;
        Start    = 1'b1;
        if (b2b) begin
            tick();
            chk({tag, "_b2b_done_low"}, {31'd0, Done}, 32'd0);
            chk({tag, "_b2b_rwe_low"}, {31'd0, RegWriteEn}, 32'd0);
        end else begin
            #1;
        end
        chk({tag, "_pcwrite_cyc0"}, {31'd0, PCWrite}, 32'd0);
        n = 0;
        busy_n = 0;
        pc_bad = 0;
        while (n < 40) begin
            tick();
            n++;
            if (Done) break;
            if (Busy) busy_n++;
            if (PCWrite) pc_bad++;
            Dividend = $urandom;
            Divisor  = $urandom;
        end
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_busy_cycles"}, busy_n, exp_lat - 1);
        chk({tag, "_pcwrite_stall"}, pc_bad, 0);
        chk({tag, "_result"}, Result, exp_res);
        chk({tag, "_rwe_done"}, {31'd0, RegWriteEn}, 32'd1);
        chk({tag, "_pcwrite_done"}, {31'd0, PCWrite}, 32'd1);
        if (!hold) begin
            Start = 1'b0;
            tick();
            chk({tag, "_done_one_cycle"}, {31'd0, Done}, 32'd0);
            chk({tag, "_result_hold"}, Result, exp_res);
        end
    endtask

    initial begin
        int pulses;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] edges [6];
        edges = '{32'd0, 32'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd7};

        // Reset behaviour, with Start asserted to show reset dominates.
        Start = 1'b1;
        #1;
        chk("rst_pcwrite_comb", {31'd0, PCWrite}, 32'd1);
        tick();
        tick();
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        chk("rst_rwe", {31'd0, RegWriteEn}, 32'd0);
        chk("rst_pcwrite", {31'd0, PCWrite}, 32'd1);
        chk("rst_result", Result, 32'd0);
        Start = 1'b0;
        CPU_rst = 1'b0;
        tick();
        chk("idle_pcwrite", {31'd0, PCWrite}, 32'd1);

        // Directed cases.
        run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 1'b0, 1'b0);
        run_op("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        run_op("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        run_op("div_5_0",    2'b00, 32'd5, 32'd0, 1'b0, 1'b0);
        run_op("remu_5_0",   2'b11, 32'd5, 32'd0, 1'b0, 1'b0);
        run_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("divu_big",   2'b01, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        run_op("div_min_2",  2'b00, 32'h8000_0000, 32'd2, 1'b0, 1'b0);

        // Back-to-back with Start held across DONE.
        run_op("b2b_divu_9_3", 2'b01, 32'd9, 32'd3, 1'b0, 1'b1);
        run_op("b2b_remu_9_4", 2'b11, 32'd9, 32'd4, 1'b1, 1'b0);

        // Reset in the middle of CALC.
        DivOp = 2'b01; Dividend = 32'd1000; Divisor = 32'd7; Start = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("abort_busy_before", {31'd0, Busy}, 32'd1);
        CPU_rst = 1'b1;
        #1;
        chk("abort_busy_comb", {31'd0, Busy}, 32'd0);
        chk("abort_pcwrite_comb", {31'd0, PCWrite}, 32'd1);
        tick();
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        chk("abort_done", {31'd0, Done}, 32'd0);
        chk("abort_result", Result, 32'd0);
        chk("abort_pcwrite", {31'd0, PCWrite}, 32'd1);
        CPU_rst = 1'b0;
        Start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (Done || Busy) pulses++;
        end
        chk("abort_no_done", pulses, 0);

        // Random operations, biased toward boundary operand values.
        for (int k = 0; k < 40; k++) begin
            op = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : 32'($urandom);
            b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)]
                                            : 32'($urandom) >> $urandom_range(0, 31);
            run_op($sformatf("rand%0d", k), op, a, b, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", r_total - r_fails, r_total);
        $finish;
    end

endmodule
`default_nettype wire
